// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus issue sequencer for the MY_DESIGN ALU stage.
// It keeps one command in flight and returns the ALU results in push order.
module alu_cmd_sequencer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [CTRL_W-1:0]        cmd_ctrl,
  input  logic [DATA_W-1:0]        cmd_a,
  input  logic [DATA_W-1:0]        cmd_b,
  output logic                     alu_valid,
  output logic [CTRL_W-1:0]        alu_ctrl,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  input  logic [DATA_W-1:0]        alu_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_W-1:0]        res_data,
  output logic [CTRL_W-1:0]        res_ctrl,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EXEC, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   fc_q [DEPTH];
  logic [DATA_W-1:0]   fa_q [DEPTH];
  logic [DATA_W-1:0]   fb_q [DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [CW-1:0]       cnt_q;
  logic [CTRL_W-1:0]   op_ctrl_q, res_ctrl_q;
  logic [DATA_W-1:0]   op_a_q, op_b_q, res_data_q;
  logic                full, push, pop;

  assign full = (cnt_q == CW'(DEPTH));
  // No pass-through: a full FIFO refuses even when it pops in the same cycle.
  assign push = cmd_valid && !full && !rst;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_EXEC;
      S_EXEC:  state_d = S_DONE;
      S_DONE: begin
        if (res_ready) begin
          if (cnt_q != '0) begin
            pop     = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fc_q[wr_q] <= cmd_ctrl;
      fa_q[wr_q] <= cmd_a;
      fb_q[wr_q] <= cmd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      op_ctrl_q  <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_data_q <= '0;
      res_ctrl_q <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (pop) begin
        op_ctrl_q <= fc_q[rd_q];
        op_a_q    <= fa_q[rd_q];
        op_b_q    <= fb_q[rd_q];
      end
      // The ALU result is valid in the cycle after the issue pulse.
      if (state_q == S_EXEC) begin
        res_data_q <= alu_out;
        res_ctrl_q <= op_ctrl_q;
      end
    end
  end

  assign cmd_ready = !full && !rst;
  assign alu_valid = (state_q == S_ISSUE) && !rst;
  assign res_valid = (state_q == S_DONE) && !rst;
  assign alu_ctrl  = rst ? '0 : op_ctrl_q;
  assign alu_a     = rst ? '0 : op_a_q;
  assign alu_b     = rst ? '0 : op_b_q;
  assign res_data  = rst ? '0 : res_data_q;
  assign res_ctrl  = rst ? '0 : res_ctrl_q;
  assign count     = rst ? '0 : cnt_q;
endmodule
